// File: rtl/lab1_pkg.sv
// Shared constants for the lab 1 switch front end: bus width and debounce
// windows for silicon (5 ms at 100 MHz) and for fast simulation.
package lab1_pkg;

    localparam int SW_WIDTH                = 8;
    localparam int DEBOUNCE_CYCLES_DEFAULT = 500000;
    localparam int DEBOUNCE_CYCLES_SIM     = 4;

    // Counter must hold 0 .. DEBOUNCE_CYCLES-1; sized on DEBOUNCE_CYCLES+1 to keep width >= 1.
    function automatic int cnt_width(input int cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/debounce_bit.sv
// One-bit switch conditioner: 2-flop synchronizer, stability counter, clean flop
// and registered edge pulses (compiled in only when SWITCH_DEBOUNCE_EDGE_EN is defined).
module debounce_bit
    import lab1_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic clean,
    output logic rise,
    output logic fall
);

    localparam int                CNT_W    = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             clean_q;
    logic             clean_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             accept;

    // Counter only runs while the synchronized sample disagrees with the clean level.
    always_comb begin
        accept  = 1'b0;
        cnt_d   = '0;
        if (sync2_q != clean_q) begin
            if (cnt_q == CNT_LAST) begin
                accept = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        clean_d = accept ? sync2_q : clean_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= '0;
            clean_q <= 1'b0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            cnt_q   <= cnt_d;
            clean_q <= clean_d;
        end
    end

    assign clean = clean_q;

`ifdef SWITCH_DEBOUNCE_EDGE_EN
    logic rise_q;
    logic rise_d;
    logic fall_q;
    logic fall_d;

    // Pulses are registered alongside clean so they coincide with its first new cycle.
    always_comb begin
        rise_d = accept & sync2_q;
        fall_d = accept & ~sync2_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign rise = rise_q;
    assign fall = fall_q;
`else
    assign rise = 1'b0;
    assign fall = 1'b0;
`endif

endmodule

// File: rtl/switch_debouncer.sv
// WIDTH-bit switch debouncer feeding the LED logic stage; each bit is an independent
// debounce_bit. Edge pulses are present only with SWITCH_DEBOUNCE_EDGE_EN defined.
module switch_debouncer
    import lab1_pkg::*;
#(
    parameter int WIDTH           = SW_WIDTH,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] switch_raw,
    output logic [WIDTH-1:0] switch_clean,
    output logic [WIDTH-1:0] switch_rise,
    output logic [WIDTH-1:0] switch_fall
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_bit (
            .clk  (clk),
            .rst  (rst),
            .raw  (switch_raw[i]),
            .clean(switch_clean[i]),
            .rise (switch_rise[i]),
            .fall (switch_fall[i])
        );
    end

endmodule

// File: doc/switch_debouncer.md
SWITCH_DEBOUNCER -- requirements
Module: switch_debouncer

Interface
- REQ-001: Parameter WIDTH, default 8: number of switch bits conditioned.
- REQ-002: Parameter DEBOUNCE_CYCLES, default 500000: consecutive stable synchronized samples required to accept a new level; legal range >= 1.
- REQ-003: clk  input  1  single system clock; all state updates on rising edge.
- REQ-004: rst  input  1  reset, asynchronous, active-high.
- REQ-005: switch_raw  input  WIDTH  raw, asynchronous, bouncing board switches.
- REQ-006: switch_clean  output  WIDTH  debounced level; this bus feeds the switch input of the downstream LED logic stage.
- REQ-007: switch_rise  output  WIDTH  one-cycle pulse per bit on an accepted 0->1 change.
- REQ-008: switch_fall  output  WIDTH  one-cycle pulse per bit on an accepted 1->0 change.

Function
- REQ-009: Each bit SHALL pass through a 2-flop synchronizer (sync1, sync2) before any other use; sync2 is the sample "s".
- REQ-010: Each bit SHALL own an independent counter of width $clog2(DEBOUNCE_CYCLES+1); bits never share state.
- REQ-011: Per bit, per edge: if s == clean, cnt <= 0.
- REQ-012: Per bit, per edge: if s != clean and cnt < DEBOUNCE_CYCLES-1, cnt <= cnt+1 and clean holds.
- REQ-013: Per bit, per edge: if s != clean and cnt == DEBOUNCE_CYCLES-1, clean <= s and cnt <= 0.
- REQ-014: Latency: raw held stable from before edge k SHALL produce the new clean value after edge k+DEBOUNCE_CYCLES+1, i.e. DEBOUNCE_CYCLES+2 edges total.
- REQ-015: Any return of s to the clean level before acceptance SHALL zero the counter; bounces shorter than DEBOUNCE_CYCLES samples never reach switch_clean.
- REQ-016: With DEBOUNCE_CYCLES == 1, a differing sample SHALL be accepted on the first edge it is seen (latency 3 edges).
- REQ-017: switch_rise[i] SHALL be high for exactly the one cycle in which switch_clean[i] first shows 1; switch_fall[i] likewise for 0; both registered, never simultaneously high.
- REQ-018: Simultaneous changes on several bits SHALL be processed in parallel with identical latency; the counter SHALL never exceed DEBOUNCE_CYCLES-1 (no wrap).
- REQ-019: The module SHALL be purely sequential in its outputs: no combinational path from switch_raw to any output.

Reset
- REQ-020: While rst is high: sync1, sync2, cnt, switch_clean, switch_rise, switch_fall SHALL all be 0, asynchronously.
- REQ-021: Reset asserted mid-count SHALL discard the count; after release a raw 1 SHALL need the full DEBOUNCE_CYCLES+2 edges, then generate a rise pulse.
- REQ-022: No edge pulse SHALL be generated by reset assertion or release itself.

Configuration
- REQ-023: Macro SWITCH_DEBOUNCE_EDGE_EN defined: switch_rise/switch_fall logic compiled in per REQ-017.
- REQ-024: Macro undefined: ports remain present, tied constant 0; edge registers not synthesized; switch_clean behaviour unchanged.

Structure
- REQ-025: Shared package lab1_pkg SHALL hold SW_WIDTH (8), DEBOUNCE_CYCLES_DEFAULT (500000, 5 ms at 100 MHz) and DEBOUNCE_CYCLES_SIM (4).
- REQ-026: One sub-module debounce_bit (synchronizer, counter, clean flop, edge flops for one bit) SHALL be instantiated WIDTH times via generate.

Verification (DEBOUNCE_CYCLES=4, macro defined unless stated)
- REQ-027: switch_raw[0] 0->1 before edge 10, held -> switch_clean[0]=1 after edge 15; switch_rise[0]=1 for that one cycle only.
- REQ-028: switch_raw[3] toggles 1 for 3 cycles, 0 for 1, repeated 20 times -> switch_clean[3] stays 0, no pulses.
- REQ-029: switch_raw 8'h00->8'hFF in one cycle -> all clean bits rise on the same edge, 8 rise pulses together; then 8'hFF->8'hA5 -> only bits 1,3,4,6 pulse fall.
- REQ-030: rst asserted 2 cycles into a count with raw=1, released -> outputs 0 immediately; clean rises 6 edges after release, no pulse at release.
- REQ-031: Macro undefined, REQ-027 stimulus -> identical switch_clean timing, switch_rise/switch_fall constantly 0.
